// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM inport arbiter: FSM states and default sizing.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_ACK,
        ARB_DRAIN
    } arb_state_t;

    localparam int ARB_NUM_REQ_DEF = 4;
    localparam int ARB_TIMEOUT_DEF = 1024;

    function automatic int arb_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Round-robin priority encoder: first set request strictly after ptr_i, wrapping.
module sdram_rr_picker
    import sdram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ_DEF,
    parameter int IDX_W   = arb_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        // Walk from farthest to nearest so the nearest pending index wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_i[IDX_W'((int'(ptr_i) + k) % NUM_REQ)]) begin
                grant_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of the SDRAM core inport, one transaction outstanding.
// Optional watchdog in WAIT_ACK enabled by defining SDRAM_ARB_WATCHDOG_EN.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = ARB_NUM_REQ_DEF,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*4-1:0]      req_wr_i,
    input  logic [NUM_REQ-1:0]        req_rd_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_accept_o,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic                      req_error_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic [3:0]                inport_wr_o,
    output logic                      inport_rd_o,
    output logic [ADDR_W-1:0]         inport_addr_o,
    output logic [DATA_W-1:0]         inport_write_data_o,
    input  logic                      inport_accept_i,
    input  logic                      inport_ack_i,
    input  logic                      inport_error_i,
    input  logic [DATA_W-1:0]         inport_read_data_i
);

    localparam int IDX_W = arb_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0][3:0]        wr_a;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
    logic [NUM_REQ-1:0]             pend;
    logic [IDX_W-1:0]               grant;
    logic                           grant_vld;

    arb_state_t         state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [3:0]         wr_q;
    logic               rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               timeout;

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q;
`endif

    assign wr_a    = req_wr_i;
    assign addr_a  = req_addr_i;
    assign wdata_a = req_wdata_i;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pend
        assign pend[i] = (|wr_a[i]) | req_rd_i[i];
    end

    sdram_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (pend),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    assign inport_wr_o         = wr_q;
    assign inport_rd_o         = rd_q;
    assign inport_addr_o       = addr_q;
    assign inport_write_data_o = wdata_q;

    // Accept/ack are zero-latency pass-throughs of the core handshake.
    always_comb begin
        req_accept_o = '0;
        req_ack_o    = '0;
        req_error_o  = 1'b0;
        req_rdata_o  = '0;
        timeout      = 1'b0;
        if (state_q == ARB_ISSUE && inport_accept_i)
            req_accept_o[owner_q] = 1'b1;
        if (state_q == ARB_WAIT_ACK) begin
            if (inport_ack_i) begin
                req_ack_o[owner_q] = 1'b1;
                req_error_o        = inport_error_i;
                req_rdata_o        = inport_read_data_i;
            end
`ifdef SDRAM_ARB_WATCHDOG_EN
            else if (wd_cnt_q == WD_LAST) begin
                req_ack_o[owner_q] = 1'b1;
                req_error_o        = 1'b1;
                timeout            = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            wr_q     <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef SDRAM_ARB_WATCHDOG_EN
            wd_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_vld) begin
                        owner_q <= grant;
                        wr_q    <= wr_a[grant];
                        rd_q    <= (wr_a[grant] == 4'h0) & req_rd_i[grant];
                        addr_q  <= addr_a[grant];
                        wdata_q <= wdata_a[grant];
                        state_q <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (inport_accept_i) begin
                        wr_q    <= '0;
                        rd_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= ARB_WAIT_ACK;
`ifdef SDRAM_ARB_WATCHDOG_EN
                        wd_cnt_q <= '0;
`endif
                    end
                end
                ARB_WAIT_ACK: begin
                    if (inport_ack_i) begin
                        rr_ptr_q <= owner_q;
                        state_q  <= ARB_IDLE;
                    end else if (timeout) begin
                        // Core still owes an ack; swallow it before granting again.
                        rr_ptr_q <= owner_q;
                        state_q  <= ARB_DRAIN;
                    end
`ifdef SDRAM_ARB_WATCHDOG_EN
                    else begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
`endif
                end
                ARB_DRAIN: begin
                    if (inport_ack_i)
                        state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences (core model, async reset, watchdog).
module tb_sdram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  req_wr = '0;
    logic [3:0]   req_rd = '0;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_accept, req_ack;
    logic         req_error;
    logic [31:0]  req_rdata;
    logic [3:0]   in_wr;
    logic         in_rd;
    logic [31:0]  in_addr, in_wdata;
    logic         in_accept = 1'b0, in_ack = 1'b0, in_error = 1'b0;
    logic [31:0]  in_rdata = '0;

    localparam logic [3:0][31:0] A_ADDR  = {32'h30, 32'h10, 32'h08, 32'h04};
    localparam logic [3:0][31:0] A_WDATA = {32'hA3A3A3A3, 32'hDEADBEEF, 32'hA1A1A1A1, 32'h12345678};

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_wr_i(req_wr), .req_rd_i(req_rd), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_accept_o(req_accept), .req_ack_o(req_ack), .req_error_o(req_error), .req_rdata_o(req_rdata),
        .inport_wr_o(in_wr), .inport_rd_o(in_rd), .inport_addr_o(in_addr), .inport_write_data_o(in_wdata),
        .inport_accept_i(in_accept), .inport_ack_i(in_ack), .inport_error_i(in_error),
        .inport_read_data_i(in_rdata)
    );

    typedef struct {
        bit          rst;
        logic [15:0] wr;
        logic [3:0]  rd;
        logic        acc, ack, err;
        logic [31:0] rdat;
        logic [3:0]  e_iwr;
        logic        e_ird;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_acc, e_ack;
        logic        e_err;
        logic [31:0] e_rdat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit r, logic [15:0] wr, logic [3:0] rd, logic ac, logic ak, logic er,
                                 logic [31:0] rdt, logic [3:0] eiwr, logic eird, int eo,
                                 logic [3:0] eac, logic [3:0] eak, logic eer, logic [31:0] erd);
        vec_t v;
        v.rst = r; v.wr = wr; v.rd = rd; v.acc = ac; v.ack = ak; v.err = er; v.rdat = rdt;
        v.e_iwr = eiwr; v.e_ird = eird;
        v.e_addr  = (eo < 0) ? 32'h0 : A_ADDR[eo];
        v.e_wdata = (eo < 0) ? 32'h0 : A_WDATA[eo];
        v.e_acc = eac; v.e_ack = eak; v.e_err = eer; v.e_rdat = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " accept"}, 64'(req_accept), 64'h0);
        chk({nm, " ack"},    64'(req_ack), 64'h0);
        chk({nm, " error"},  64'(req_error), 64'h0);
        chk({nm, " rdata"},  64'(req_rdata), 64'h0);
        chk({nm, " strobe"}, 64'({in_wr, in_rd}), 64'h0);
        chk({nm, " addr"},   64'(in_addr), 64'h0);
    endtask

    task automatic do_reset();
        req_wr = '0; req_rd = '0;
        in_accept = 0; in_ack = 0; in_error = 0; in_rdata = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tiny core stand-in: accepts any strobe at once, acks the following cycle.
    logic [31:0] mem [logic [31:0]];

    task automatic run_core(input int who, output logic [3:0] ackv, output logic [31:0] rdv,
                            output logic erv, output bit got);
        logic        ack_nxt = 1'b0;
        logic [31:0] lat_addr = '0;
        got = 0; ackv = '0; rdv = '0; erv = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            in_ack    = ack_nxt;
            in_error  = 1'b0;
            in_rdata  = (ack_nxt && mem.exists(lat_addr)) ? mem[lat_addr] : 32'h0;
            in_accept = (in_wr != 4'h0) || in_rd;
            #1;
            if (req_accept[who]) begin
                req_wr[who*4 +: 4] = 4'h0;
                req_rd[who] = 1'b0;
            end
            if (req_ack != 4'h0) begin
                got = 1; ackv = req_ack; rdv = req_rdata; erv = req_error;
            end
            ack_nxt = 1'b0;
            if (in_accept) begin
                lat_addr = in_addr;
                if (in_wr != 4'h0) begin
                    logic [31:0] w;
                    w = mem.exists(in_addr) ? mem[in_addr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (in_wr[b]) w[b*8 +: 8] = in_wdata[b*8 +: 8];
                    mem[in_addr] = w;
                end
                ack_nxt = 1'b1;
            end
        end
        @(negedge clk);
        in_ack = 0; in_accept = 0; in_rdata = '0;
    endtask

    initial begin
        logic [3:0]  ackv;
        logic [31:0] rdv;
        logic        erv;
        bit          got;
        int          hit;

        req_addr  = A_ADDR;
        req_wdata = A_WDATA;

        // Reset state
        #1;
        chk_all_zero("reset");

        // Single write from requester 2, then an ack outside WAIT_ACK that must be ignored
        tbl.push_back(mkv(1, 16'h0F00, 4'h0, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0F00, 4'h0, 0, 0, 0, 32'h0,  4'hF, 0,  2, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0F00, 4'h0, 1, 0, 0, 32'h0,  4'hF, 0,  2, 4'h4, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 0, 1, 0, 32'h55, 4'h0, 0, -1, 4'h0, 4'h4, 0, 32'h55));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 0, 1, 1, 32'h77, 4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        // Contention: all four read, order 0,1,2,3; then 0 and 3 re-request with rr_ptr=3
        tbl.push_back(mkv(1, 16'h0, 4'hF, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'hF, 1, 0, 0, 32'h0,  4'h0, 1,  0, 4'h1, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'hE, 0, 1, 0, 32'hA0, 4'h0, 0, -1, 4'h0, 4'h1, 0, 32'hA0));
        tbl.push_back(mkv(0, 16'h0, 4'hE, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'hE, 1, 0, 0, 32'h0,  4'h0, 1,  1, 4'h2, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'hC, 0, 1, 0, 32'hB1, 4'h0, 0, -1, 4'h0, 4'h2, 0, 32'hB1));
        tbl.push_back(mkv(0, 16'h0, 4'hC, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'hC, 1, 0, 0, 32'h0,  4'h0, 1,  2, 4'h4, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 0, 1, 0, 32'hC2, 4'h0, 0, -1, 4'h0, 4'h4, 0, 32'hC2));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 1, 0, 0, 32'h0,  4'h0, 1,  3, 4'h8, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h9, 0, 1, 0, 32'hD3, 4'h0, 0, -1, 4'h0, 4'h8, 0, 32'hD3));
        tbl.push_back(mkv(0, 16'h0, 4'h9, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h9, 1, 0, 0, 32'h0,  4'h0, 1,  0, 4'h1, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 0, 1, 0, 32'hE0, 4'h0, 0, -1, 4'h0, 4'h1, 0, 32'hE0));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h8, 1, 0, 0, 32'h0,  4'h0, 1,  3, 4'h8, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0, 4'h0, 0, 1, 1, 32'hEE, 4'h0, 0, -1, 4'h0, 4'h8, 1, 32'hEE));
        tbl.push_back(mkv(0, 16'h0, 4'h0, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        // Back-to-back: accept stall, wr+rd treated as write, re-assert in ack cycle -> one bubble
        tbl.push_back(mkv(1, 16'h0030, 4'h0, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0030, 4'h0, 0, 0, 0, 32'h0,  4'h3, 0,  1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0030, 4'h0, 1, 0, 0, 32'h0,  4'h3, 0,  1, 4'h2, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 1, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0030, 4'h2, 0, 1, 0, 32'h11, 4'h0, 0, -1, 4'h0, 4'h2, 0, 32'h11));
        tbl.push_back(mkv(0, 16'h0030, 4'h2, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0030, 4'h2, 1, 0, 0, 32'h0,  4'h3, 0,  1, 4'h2, 4'h0, 0, 32'h0));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 0, 1, 0, 32'h22, 4'h0, 0, -1, 4'h0, 4'h2, 0, 32'h22));
        tbl.push_back(mkv(0, 16'h0000, 4'h0, 0, 0, 0, 32'h0,  4'h0, 0, -1, 4'h0, 4'h0, 0, 32'h0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            @(negedge clk);
            req_wr = tbl[i].wr; req_rd = tbl[i].rd;
            in_accept = tbl[i].acc; in_ack = tbl[i].ack; in_error = tbl[i].err; in_rdata = tbl[i].rdat;
            #1;
            chk($sformatf("v%0d inport_wr", i),   64'(in_wr),      64'(tbl[i].e_iwr));
            chk($sformatf("v%0d inport_rd", i),   64'(in_rd),      64'(tbl[i].e_ird));
            chk($sformatf("v%0d inport_addr", i), 64'(in_addr),    64'(tbl[i].e_addr));
            chk($sformatf("v%0d inport_wdat", i), 64'(in_wdata),   64'(tbl[i].e_wdata));
            chk($sformatf("v%0d accept", i),      64'(req_accept), 64'(tbl[i].e_acc));
            chk($sformatf("v%0d ack", i),         64'(req_ack),    64'(tbl[i].e_ack));
            chk($sformatf("v%0d error", i),       64'(req_error),  64'(tbl[i].e_err));
            chk($sformatf("v%0d rdata", i),       64'(req_rdata),  64'(tbl[i].e_rdat));
        end

        // Write then read back through the core stand-in
        do_reset();
        req_addr[63:32] = 32'h4;
        req_wr[3:0] = 4'hF;
        run_core(0, ackv, rdv, erv, got);
        chk("wb write done", 64'(got), 64'h1);
        chk("wb write ack",  64'(ackv), 64'h1);
        req_rd[1] = 1'b1;
        run_core(1, ackv, rdv, erv, got);
        chk("wb read done",  64'(got), 64'h1);
        chk("wb read ack",   64'(ackv), 64'h2);
        chk("wb read data",  64'(rdv), 64'h12345678);
        chk("wb read error", 64'(erv), 64'h0);
        req_addr = A_ADDR;

        // Async reset while waiting for the core ack
        do_reset();
        @(negedge clk); req_rd = 4'h4;
        @(negedge clk); in_accept = 1'b1;
        #1 chk("rst issue accept", 64'(req_accept), 64'h4);
        @(negedge clk); req_rd = 4'h0; in_accept = 1'b0;
        #2; in_ack = 1'b1; in_error = 1'b1; in_rdata = 32'hFFFF_FFFF; rst = 1'b1;
        #1 chk_all_zero("rst mid");
        @(negedge clk); rst = 1'b0; in_ack = 1'b0; in_error = 1'b0; in_rdata = '0;
        req_rd = 4'h2;
        #1 chk_all_zero("rst idle");
        @(negedge clk);
        #1;
        chk("rst regrant rd",   64'(in_rd), 64'h1);
        chk("rst regrant addr", 64'(in_addr), 64'h08);

`ifdef SDRAM_ARB_WATCHDOG_EN
        // Watchdog: ack withheld, timeout on the 16th WAIT_ACK cycle, stale ack discarded
        do_reset();
        @(negedge clk); req_rd = 4'h1;
        @(negedge clk); in_accept = 1'b1;
        hit = 0;
        for (int n = 1; n <= 20 && hit == 0; n++) begin
            @(negedge clk); req_rd = 4'h0; in_accept = 1'b0;
            #1;
            if (req_ack != 4'h0) begin
                hit = n;
                chk("wd ack",   64'(req_ack), 64'h1);
                chk("wd error", 64'(req_error), 64'h1);
                chk("wd rdata", 64'(req_rdata), 64'h0);
            end
        end
        chk("wd cycle", 64'(hit), 64'd16);
        @(negedge clk); in_ack = 1'b1; in_rdata = 32'h5A5A5A5A;
        #1 chk("wd stale ack", 64'(req_ack), 64'h0);
        @(negedge clk); in_ack = 1'b0; in_rdata = '0; req_wr = 16'h0F00;
        @(negedge clk);
        #1 chk("wd next req", 64'(in_wr), 64'hF);
`else
        hit = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
